// File: rtl/ctrl_intersection.sv
// Two-approach intersection sequencer: main road rests in green, latched side request served after minimum green.
// Phase changes happen only on prescaler ticks; heads are decoded combinationally from the current phase.
module ctrl_intersection #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned SIDE_GREEN = 5,
  parameter int unsigned YELLOW     = 2,
  parameter int unsigned ALLRED     = 1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req,
  output logic [2:0] main_rgb,
  output logic [2:0] side_rgb,
  output logic [2:0] phase,
  output logic       req_pending,
  output logic       tick
);

  localparam int unsigned MAX_AB  = (MIN_GREEN > SIDE_GREEN) ? MIN_GREEN : SIDE_GREEN;
  localparam int unsigned MAX_CD  = (YELLOW > ALLRED) ? YELLOW : ALLRED;
  localparam int unsigned MAXD    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned PW      = $clog2(TICK_DIV);
  localparam int unsigned TW      = $clog2(MAXD + 1);

  if (TICK_DIV < 2 || MIN_GREEN < 1 || SIDE_GREEN < 1 || YELLOW < 1 || ALLRED < 1) begin : g_bad_param
    $error("ctrl_intersection: durations must be >=1 and TICK_DIV >=2");
  end

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN_P= 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b110;
  localparam logic [2:0] GRN = 3'b010;

  phase_e          phase_q, phase_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pend_q,  pend_d;
  logic [TW-1:0]   last_tick;

  assign tick        = (presc_q == PW'(TICK_DIV - 1));
  assign phase       = phase_q;
  assign req_pending = pend_q;

  // Timer value on whose tick a timed phase ends.
  always_comb begin
    last_tick = '0;
    case (phase_q)
      MAIN_YELLOW, SIDE_YELLOW: last_tick = TW'(YELLOW - 1);
      ALLRED_A, ALLRED_B:       last_tick = TW'(ALLRED - 1);
      SIDE_GREEN_P:             last_tick = TW'(SIDE_GREEN - 1);
      default:                  last_tick = '0;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    timer_d = timer_q;
    pend_d  = pend_q | (req && (phase_q != SIDE_GREEN_P));

    if (tick) begin
      if (phase_q != MAIN_GREEN || 32'(timer_q) < MIN_GREEN) begin
        timer_d = timer_q + 1'b1;
      end
    end

    case (phase_q)
      MAIN_GREEN: begin
        if (tick && (32'(timer_q) + 32'd1 >= MIN_GREEN) && pend_q) phase_d = MAIN_YELLOW;
      end
      MAIN_YELLOW:  if (tick && timer_q == last_tick) phase_d = ALLRED_A;
      ALLRED_A:     if (tick && timer_q == last_tick) phase_d = SIDE_GREEN_P;
      SIDE_GREEN_P: if (tick && timer_q == last_tick) phase_d = SIDE_YELLOW;
      SIDE_YELLOW:  if (tick && timer_q == last_tick) phase_d = ALLRED_B;
      ALLRED_B:     if (tick && timer_q == last_tick) phase_d = MAIN_GREEN;
      default:      phase_d = ALLRED_B;
    endcase

    // Entering a phase restarts its timing; entering side green consumes the request.
    if (phase_d != phase_q) begin
      presc_d = '0;
      timer_d = '0;
      if (phase_d == SIDE_GREEN_P) pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase_q <= ALLRED_B;
      presc_q <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    main_rgb = RED;
    side_rgb = RED;
    case (phase_q)
      MAIN_GREEN:   main_rgb = GRN;
      MAIN_YELLOW:  main_rgb = YEL;
      SIDE_GREEN_P: side_rgb = GRN;
      SIDE_YELLOW:  side_rgb = YEL;
      default: begin
        main_rgb = RED;
        side_rgb = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_intersection.sv
// Directed bench for ctrl_intersection with small timing parameters; samples on the falling clock edge.
module tb_ctrl_intersection;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       req = 1'b0;
  logic [2:0] main_rgb, side_rgb, phase;
  logic       req_pending, tick;

  int n_chk  = 0;
  int n_pass = 0;

  ctrl_intersection #(
    .TICK_DIV(4), .MIN_GREEN(3), .SIDE_GREEN(2), .YELLOW(2), .ALLRED(1)
  ) dut (
    .clk(clk), .res(res), .req(req),
    .main_rgb(main_rgb), .side_rgb(side_rgb), .phase(phase),
    .req_pending(req_pending), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] exp_main(input int p);
    case (p)
      0: return 3'b010;
      1: return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int p);
    case (p)
      3: return 3'b010;
      4: return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  // Called on the first falling edge inside phase p; returns on the first falling edge after it.
  task automatic run_phase(input int p, input int n);
    int k = 0;
    chk($sformatf("phase_%0d_entry", p), phase, p);
    chk($sformatf("main_rgb_ph%0d", p), main_rgb, exp_main(p));
    chk($sformatf("side_rgb_ph%0d", p), side_rgb, exp_side(p));
    while (phase == 3'(p) && k < n + 16) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("len_ph%0d", p), k, n);
  endtask

  // Main-green with optional 1-clk request pulse at cycle pulse_at (-1 = none).
  task automatic run_mg(input int pulse_at, input int exp_len);
    int k = 0;
    chk("mg_entry", phase, 0);
    chk("mg_main_rgb", main_rgb, 3'b010);
    chk("mg_side_rgb", side_rgb, 3'b100);
    while (phase == 3'd0 && k < exp_len + 16) begin
      chk($sformatf("mg_tick_k%0d", k), tick, (k % 4 == 3) ? 1 : 0);
      if (k == pulse_at) req = 1'b1;
      if (k == pulse_at + 1) begin
        req = 1'b0;
        chk("mg_pending_after_pulse", req_pending, 1);
      end
      @(negedge clk);
      k++;
    end
    req = 1'b0;
    chk("mg_len", k, exp_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 res = 1'b0;
    #1;
    chk("rst_phase", phase, 5);
    chk("rst_main", main_rgb, 3'b100);
    chk("rst_side", side_rgb, 3'b100);
    chk("rst_pending", req_pending, 0);
    chk("rst_tick", tick, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_phase", phase, 5);
    res = 1'b1;

    // Idle sequence: ALLRED_B, then main green held, then a late request served at the next tick.
    run_phase(5, 4);
    run_mg(202, 204);
    run_phase(1, 8);
    run_phase(2, 4);
    run_phase(3, 8);
    run_phase(4, 8);
    run_phase(5, 4);

    // Request at clk 2 of a fresh main green.
    run_mg(2, 12);
    run_phase(1, 8);
    run_phase(2, 4);

    // Request held through side green is ignored, then latches in side yellow.
    begin
      int k = 0;
      chk("sg_entry", phase, 3);
      req = 1'b1;
      while (phase == 3'd3 && k < 24) begin
        chk($sformatf("sg_pending_k%0d", k), req_pending, 0);
        @(negedge clk);
        k++;
      end
      chk("sg_len_req_held", k, 8);
      chk("sy_entry", phase, 4);
      chk("sy_pending_at_entry", req_pending, 0);
      @(negedge clk);
      req = 1'b0;
      chk("sy_pending_set", req_pending, 1);
      run_phase(4, 7);
    end
    run_phase(5, 4);
    run_mg(-1, 12);
    run_phase(1, 8);
    run_phase(2, 4);

    // Asynchronous reset in the middle of side green.
    chk("pre_rst_phase", phase, 3);
    repeat (3) @(negedge clk);
    chk("pre_rst_tick", tick, 1);
    #2 res = 1'b0;
    #1;
    chk("midrst_phase", phase, 5);
    chk("midrst_main", main_rgb, 3'b100);
    chk("midrst_side", side_rgb, 3'b100);
    chk("midrst_pending", req_pending, 0);
    chk("midrst_tick", tick, 0);
    @(negedge clk);
    res = 1'b1;
    run_phase(5, 4);

    // Random sparse requests: safety and legal phase codes.
    for (int i = 0; i < 10000; i++) begin
      req = ($urandom_range(0, 7) == 0);
      chk("safety", (main_rgb != 3'b100 && side_rgb != 3'b100) ? 1 : 0, 0);
      chk("phase_legal", (phase <= 3'd5) ? 1 : 0, 1);
      @(negedge clk);
    end
    req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
